// File: rtl/ac97_pkg.sv
// Shared AC'97 link constants: frame geometry, slot offsets, codec register map,
// and the codec command record used between the command ROM and the frame builder.
package ac97_pkg;
   localparam int FRAME_BITS  = 256;
   localparam int TAG_BITS    = 16;
   localparam int SLOT_BITS   = 20;
   localparam int CNT_W       = $clog2(FRAME_BITS);

   localparam int SLOT1_START = TAG_BITS;
   localparam int SLOT2_START = SLOT1_START + SLOT_BITS;
   localparam int SLOT3_START = SLOT2_START + SLOT_BITS;
   localparam int SLOT4_START = SLOT3_START + SLOT_BITS;
   // Only tag + slots 1..4 carry data; everything past this is zero.
   localparam int HEAD_BITS   = SLOT4_START + SLOT_BITS;
   localparam int HEAD_IDX_W  = $clog2(HEAD_BITS);

   localparam logic [6:0] REG_MASTER    = 7'h02;
   localparam logic [6:0] REG_HEADPHONE = 7'h04;
   localparam logic [6:0] REG_PCM_OUT   = 7'h18;
   localparam logic [6:0] REG_REC_SEL   = 7'h1A;

   typedef struct packed {
      logic [6:0]  reg_idx;
      logic [15:0] reg_data;
   } codec_cmd_t;

   // Same attenuation on both channels; 1.5 dB steps mapped onto the 6-bit field.
   function automatic logic [15:0] vol_word(input logic [3:0] vol);
      logic [5:0] att;
      att = {1'b0, vol, 1'b0};
      return {2'b00, att, 2'b00, att};
   endfunction
endpackage

// File: rtl/ac97_cmd_rom.sv
// Repeating codec register-write list; volume words track volume_control live.
module ac97_cmd_rom
   import ac97_pkg::*;
#(
   parameter int IDX_W = 2
) (
   input  logic [IDX_W-1:0] cmd_idx,
   input  logic [3:0]       volume_control,
   output codec_cmd_t       cmd
);
   always_comb begin
      cmd = '0;
      case (cmd_idx)
         IDX_W'(0): cmd = '{reg_idx: REG_MASTER,    reg_data: vol_word(volume_control)};
         IDX_W'(1): cmd = '{reg_idx: REG_HEADPHONE, reg_data: vol_word(volume_control)};
         IDX_W'(2): cmd = '{reg_idx: REG_PCM_OUT,   reg_data: 16'h0808};
         IDX_W'(3): cmd = '{reg_idx: REG_REC_SEL,   reg_data: 16'h0000};
         default:   cmd = '0;
      endcase
   end
endmodule

// File: rtl/ac97_frame_controller.sv
// AC'97 link master: serialises 256-bit frames (tag, command, mono PCM on L/R)
// and pops one FIFO sample per frame once the codec reports ready.
module ac97_frame_controller
   import ac97_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 20,
   parameter int NUM_CMDS     = 4
) (
   input  logic                    bit_clk,
   input  logic                    system_reset,
   input  logic                    sdata_in,
   output logic                    sdata_out,
   output logic                    sync,
   output logic                    reset_b,
   input  logic [SAMPLE_WIDTH-1:0] sample_fifo_dout,
   input  logic                    sample_fifo_empty,
   output logic                    sample_fifo_rd_en,
   input  logic [3:0]              volume_control
);
   localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;

   logic [CNT_W-1:0]        bit_cnt;
   logic                    running;
   logic                    codec_ready;
   logic                    frame_ready;
   logic [IDX_W-1:0]        cmd_idx;
   codec_cmd_t              rom_cmd, cur_cmd;
   logic [SAMPLE_WIDTH-1:0] sample_q;
   logic                    sdata_q;
   logic                    frame_end;
   logic [HEAD_BITS-1:0]    frame_head;
   logic [HEAD_IDX_W-1:0]   head_pos;
   logic                    head_bit;

   ac97_cmd_rom #(.IDX_W(IDX_W)) u_cmd_rom (
      .cmd_idx        (cmd_idx),
      .volume_control (volume_control),
      .cmd            (rom_cmd)
   );

   // running holds the counter at 0 for one cycle after reset so the first
   // visible frame begins cleanly at b=0.
   assign frame_end = running && (bit_cnt == CNT_W'(FRAME_BITS-1));
   assign reset_b   = ~system_reset;
   assign sync      = running && (bit_cnt < CNT_W'(TAG_BITS));
   assign sdata_out = sdata_q;
   assign sample_fifo_rd_en = frame_end && codec_ready && !sample_fifo_empty && !system_reset;

   // Everything feeding the frame is latched at b=255, so a frame is self-consistent.
   assign frame_head = {frame_ready, {4{frame_ready}}, 11'b0,
                        1'b0, cur_cmd.reg_idx, 12'b0,
                        cur_cmd.reg_data, 4'b0,
                        SLOT_BITS'(sample_q),
                        SLOT_BITS'(sample_q)};
   assign head_pos = HEAD_IDX_W'(HEAD_BITS-1) - bit_cnt[HEAD_IDX_W-1:0];
   assign head_bit = (bit_cnt < CNT_W'(HEAD_BITS)) && frame_head[head_pos];

   always_ff @(posedge bit_clk) begin
      if (system_reset) begin
         running     <= 1'b0;
         bit_cnt     <= '0;
         sdata_q     <= 1'b0;
         codec_ready <= 1'b0;
         frame_ready <= 1'b0;
         cmd_idx     <= '0;
         cur_cmd     <= '0;
         sample_q    <= '0;
      end else begin
         running <= 1'b1;
         if (running) bit_cnt <= bit_cnt + 1'b1;
         // Registering frame bit b here yields the one-cycle lag on the wire.
         sdata_q <= running && head_bit;
         if (running && bit_cnt == CNT_W'(1) && sdata_in) codec_ready <= 1'b1;
         if (frame_end) begin
            frame_ready <= codec_ready;
            cur_cmd     <= rom_cmd;
            cmd_idx     <= (cmd_idx == IDX_W'(NUM_CMDS-1)) ? '0 : cmd_idx + 1'b1;
            if (sample_fifo_rd_en) sample_q <= sample_fifo_dout;
         end
      end
   end
endmodule

// File: tb/tb_ac97_frame_controller.sv
// Directed bench: captures whole serial frames and checks tag, command and PCM slots.
module tb_ac97_frame_controller;
   logic        bit_clk = 1'b0;
   logic        system_reset;
   logic        sdata_in;
   logic        sdata_out;
   logic        sync;
   logic        reset_b;
   logic [19:0] sample_fifo_dout;
   logic        sample_fifo_empty;
   logic        sample_fifo_rd_en;
   logic [3:0]  volume_control;

   int n_checks = 0;
   int n_pass   = 0;
   int fifo_q[$];
   logic pop_pend = 1'b0;
   int rd_bad = 0;
   logic fr [256];
   int pops, sync_err;

   typedef struct {
      logic [3:0]  vol;
      logic [15:0] exp_vol_data;
   } vol_vec_t;
   vol_vec_t vv [4];
   logic [6:0] exp_regs [4];

   always #5 bit_clk = ~bit_clk;

   ac97_frame_controller dut (
      .bit_clk           (bit_clk),
      .system_reset      (system_reset),
      .sdata_in          (sdata_in),
      .sdata_out         (sdata_out),
      .sync              (sync),
      .reset_b           (reset_b),
      .sample_fifo_dout  (sample_fifo_dout),
      .sample_fifo_empty (sample_fifo_empty),
      .sample_fifo_rd_en (sample_fifo_rd_en),
      .volume_control    (volume_control)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic upd_fifo();
      int t;
      sample_fifo_empty = (fifo_q.size() == 0);
      if (fifo_q.size() > 0) begin
         t = fifo_q[0];
         sample_fifo_dout = t[19:0];
      end else sample_fifo_dout = 20'h0;
   endtask

   task automatic tick();
      int t;
      @(posedge bit_clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) t = fifo_q.pop_front();
      upd_fifo();
      #1;
      pop_pend = sample_fifo_rd_en;
      if (sample_fifo_rd_en && sample_fifo_empty) rd_bad++;
   endtask

   // Called at a b=0 cycle; ends at the next b=0 cycle. Tick t shows frame bit t-1.
   task automatic capture_frame();
      pops = 0;
      sync_err = 0;
      for (int t = 1; t <= 256; t++) begin
         tick();
         fr[t-1] = sdata_out;
         if (sample_fifo_rd_en) pops++;
         if (sync !== ((t < 16) || (t == 256))) sync_err++;
      end
   endtask

   function automatic logic [31:0] field(input int start, input int len);
      logic [31:0] v;
      v = '0;
      for (int i = start; i < start + len; i++) v = {v[30:0], fr[i]};
      return v;
   endfunction

   task automatic wait_sync(input string name);
      int n;
      n = 0;
      while (sync !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check(name, 32'(sync), 32'h1);
   endtask

   initial begin
      int s;
      int p;
      logic [19:0] e;
      logic [6:0]  r;
      logic [15:0] d;

      vv[0] = '{4'd0,  16'h0000};
      vv[1] = '{4'd15, 16'h1E1E};
      vv[2] = '{4'd5,  16'h0A0A};
      vv[3] = '{4'd8,  16'h1010};
      exp_regs[0] = 7'h02; exp_regs[1] = 7'h04; exp_regs[2] = 7'h18; exp_regs[3] = 7'h1A;

      system_reset   = 1'b1;
      sdata_in       = 1'b0;
      volume_control = 4'd0;
      for (int k = -50; k <= 50; k++) fifo_q.push_back(k);
      upd_fifo();

      // Reset: outputs quiet, codec held in reset.
      for (int i = 0; i < 8; i++) begin
         tick();
         check("reset_outputs", {28'h0, reset_b, sync, sample_fifo_rd_en, sdata_out}, 32'h0);
      end
      system_reset = 1'b0;
      tick();
      check("reset_b_released", 32'(reset_b), 32'h1);
      wait_sync("first_sync");

      // Codec not ready: nothing valid, no pops.
      for (int f = 0; f < 3; f++) begin
         capture_frame();
         check("notready_tag", field(0, 16), 32'h0);
         check("notready_pops", 32'(pops), 32'h0);
         check("notready_slot3", field(56, 20), 32'h0);
         check("sync_pattern", 32'(sync_err), 32'h0);
      end

      // Codec ready: the first fetch happens at the end of this frame.
      sdata_in = 1'b1;
      capture_frame();
      check("first_fetch_pops", 32'(pops), 32'h1);

      for (int k = -50; k <= 50; k++) begin
         capture_frame();
         e = 20'(k);
         check("ready_tag", field(0, 16), 32'h0000F800);
         check("slot3_sample", field(56, 20), 32'(e));
         check("slot4_sample", field(76, 20), 32'(e));
         check("pops_per_frame", 32'(pops), (k == 50) ? 32'h0 : 32'h1);
         check("sync_pattern", 32'(sync_err), 32'h0);
      end

      // FIFO drained: last sample repeats, no pops.
      for (int f = 0; f < 10; f++) begin
         capture_frame();
         check("drained_slot3", field(56, 20), 32'h32);
         check("drained_slot4", field(76, 20), 32'h32);
         check("drained_pops", 32'(pops), 32'h0);
      end

      // Command rotation and volume mapping.
      for (int v = 0; v < 4; v++) begin
         volume_control = vv[v].vol;
         capture_frame();
         p = -1;
         for (int f = 0; f < 4; f++) begin
            capture_frame();
            r = field(17, 7);
            if (f == 0)
               for (int j = 0; j < 4; j++) if (exp_regs[j] == r) p = j;
            if (p < 0) begin
               check("cmd_reg_known", 32'(r), 32'h02);
               break;
            end
            r = exp_regs[(p + f) % 4];
            d = (r == 7'h02 || r == 7'h04) ? vv[v].exp_vol_data :
                (r == 7'h18) ? 16'h0808 : 16'h0000;
            check("slot1_cmd", field(16, 20), {12'h0, 1'b0, r, 12'h0});
            check("slot2_data", field(36, 20), {12'h0, d, 4'h0});
         end
      end

      // Reset at b=100.
      for (int i = 0; i < 100; i++) tick();
      system_reset = 1'b1;
      tick();
      check("midreset_outputs", {28'h0, reset_b, sync, sample_fifo_rd_en, sdata_out}, 32'h0);
      tick();
      tick();
      system_reset = 1'b0;
      wait_sync("resync_after_reset");
      capture_frame();
      check("post_reset_slot3", field(56, 20), 32'h0);
      check("post_reset_tag", field(0, 16), 32'h0);

      // Reset during the sync window must drop sync immediately.
      for (int i = 0; i < 8; i++) tick();
      s = 32'(sync);
      check("sync_before_reset", s, 32'h1);
      system_reset = 1'b1;
      tick();
      check("sync_after_reset", 32'(sync), 32'h0);
      system_reset = 1'b0;
      wait_sync("resync_second");

      check("rd_en_while_empty", 32'(rd_bad), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
